// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: channel map,
// default counter width and the wrap/saturate mode encodings.
package perf_pkg;

  // Channel assignment used by the CPU integration
  localparam int EV_CYCLE      = 0;
  localparam int EV_CONDI_BR   = 1;
  localparam int EV_UNCONDI_BR = 2;
  localparam int EV_STALL      = 3;

  // Default counter width
  localparam int CNT_W_DEFAULT = 32;

  // Arithmetic mode at the all-ones boundary
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter channel: enable-gated increment, synchronous clear with
// priority over counting, wrap or saturate at all-ones, sticky overflow flag.
// nxt_o exposes the value the counter will hold after the coming edge so the
// top level can snapshot post-update values.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter bit SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] nxt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             at_max_s;

  assign at_max_s = &cnt_q;

  // Next-state: clear beats increment; all-ones either wraps or holds
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (at_max_s) begin
        ovf_d = 1'b1;
        if (SATURATE == MODE_SAT) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = {CNT_W{1'b0}};
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
    end
  end

  // Counter and overflow registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign nxt_o = cnt_d;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with pause gating, a latching halt, atomic
// snapshot into shadow registers and a registered shadow read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  CNT_W    = CNT_W_DEFAULT,
  parameter bit  SATURATE = MODE_WRAP,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              halt,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              clear,
  input  logic              snap,
  input  logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              halted,
  output logic              snap_valid
);

  logic                           halted_q;
  logic                           halted_d;
  logic                           snap_valid_q;
  logic                           snap_valid_d;
  logic [CNT_W-1:0]               rd_data_q;
  logic [CNT_W-1:0]               rd_data_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   shadow_q;
  logic [NUM_CH-1:0][CNT_W-1:0]   shadow_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   nxt_s;
  logic [NUM_CH-1:0]              en_s;
  logic [NUM_CH-1:0]              ovf_s;
  logic                           snap_s;

  // The first halt cycle doubles as a snapshot request
  assign snap_s = snap | (halt & ~halted_q);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign en_s[k] = event_i[k] & ~pause & ~halted_q;

    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en_s[k]),
      .clr_i (clear),
      .nxt_o (nxt_s[k]),
      .ovf_o (ovf_s[k])
    );
  end

  // Halt latch, snapshot capture of post-update values, and read mux
  always_comb begin
    halted_d     = halted_q | halt;
    snap_valid_d = snap_valid_q | snap_s;
    shadow_d     = shadow_q;
    rd_data_d    = {CNT_W{1'b0}};
    if (snap_s) begin
      shadow_d = nxt_s;
    end else begin
      shadow_d = shadow_q;
    end
    // AND-OR mux: out-of-range selects match no channel and read 0
    for (int k = 0; k < NUM_CH; k++) begin
      rd_data_d = rd_data_d | ({CNT_W{sel == SEL_W'(k)}} & shadow_q[k]);
    end
  end

  // Control, shadow and readout registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      halted_q     <= 1'b0;
      snap_valid_q <= 1'b0;
      shadow_q     <= '0;
      rd_data_q    <= {CNT_W{1'b0}};
    end else begin
      halted_q     <= halted_d;
      snap_valid_q <= snap_valid_d;
      shadow_q     <= shadow_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign ovf        = ovf_s;
  assign halted     = halted_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank. Four instances share stimulus:
// a default 32-bit wrap bank, 4-bit wrap and 4-bit saturate banks, and a
// 3-channel bank for the out-of-range select case.
module tb_perf_counter_bank;

  logic        clk;
  logic        rst;
  logic        pause;
  logic        halt;
  logic        clear;
  logic        snap;
  logic [3:0]  event_i;
  logic [1:0]  sel;

  logic [31:0] m_rd;
  logic [3:0]  m_ovf;
  logic        m_halted;
  logic        m_sv;
  logic [3:0]  w_rd;
  logic [3:0]  w_ovf;
  logic        w_halted;
  logic        w_sv;
  logic [3:0]  s_rd;
  logic [3:0]  s_ovf;
  logic        s_halted;
  logic        s_sv;
  logic [7:0]  n_rd;
  logic [2:0]  n_ovf;
  logic        n_halted;
  logic        n_sv;

  int n_checks;
  int n_fail;

  perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .SATURATE(1'b0)) u_main (
    .clk(clk), .rst(rst), .pause(pause), .halt(halt), .event_i(event_i),
    .clear(clear), .snap(snap), .sel(sel), .rd_data(m_rd), .ovf(m_ovf),
    .halted(m_halted), .snap_valid(m_sv)
  );

  perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .pause(pause), .halt(halt), .event_i(event_i),
    .clear(clear), .snap(snap), .sel(sel), .rd_data(w_rd), .ovf(w_ovf),
    .halted(w_halted), .snap_valid(w_sv)
  );

  perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .pause(pause), .halt(halt), .event_i(event_i),
    .clear(clear), .snap(snap), .sel(sel), .rd_data(s_rd), .ovf(s_ovf),
    .halted(s_halted), .snap_valid(s_sv)
  );

  perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SATURATE(1'b0)) u_n3 (
    .clk(clk), .rst(rst), .pause(pause), .halt(halt), .event_i(event_i[2:0]),
    .clear(clear), .snap(snap), .sel(sel), .rd_data(n_rd), .ovf(n_ovf),
    .halted(n_halted), .snap_valid(n_sv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; pause = 1'b0; halt = 1'b0; clear = 1'b0; snap = 1'b0;
    event_i = 4'b0000; sel = 2'd0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (m_rd !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", m_rd); end
    n_checks++; if (m_ovf !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", m_ovf); end
    n_checks++; if (m_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", m_halted); end
    n_checks++; if (m_sv !== 1'b0) begin n_fail++; $display("FAIL reset_snap_valid: got %b expected 0", m_sv); end
  endtask

  task automatic test_basic_count();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      event_i = 4'b0001;
      pause = (i == 3 || i == 4);
      cyc();
    end
    event_i = 4'b0000; pause = 1'b0; snap = 1'b1; sel = 2'd0;
    cyc();
    snap = 1'b0;
    n_checks++; if (m_rd !== 32'd0) begin n_fail++; $display("FAIL basic_rd_latency: got %0d expected 0", m_rd); end
    n_checks++; if (m_sv !== 1'b1) begin n_fail++; $display("FAIL basic_snap_valid: got %b expected 1", m_sv); end
    cyc();
    n_checks++; if (m_rd !== 32'd8) begin n_fail++; $display("FAIL basic_rd: got %0d expected 8", m_rd); end
    n_checks++; if (m_ovf !== 4'b0000) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0000", m_ovf); end
  endtask

  task automatic test_clear_snap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      event_i = 4'b0010;
      cyc();
    end
    event_i = 4'b0000; snap = 1'b1; sel = 2'd1;
    cyc();
    snap = 1'b0;
    cyc();
    n_checks++; if (m_rd !== 32'd5) begin n_fail++; $display("FAIL clrsnap_pre: got %0d expected 5", m_rd); end
    clear = 1'b1; snap = 1'b1; event_i = 4'b0010;
    cyc();
    clear = 1'b0; snap = 1'b0; event_i = 4'b0000;
    n_checks++; if (m_sv !== 1'b1) begin n_fail++; $display("FAIL clrsnap_valid: got %b expected 1", m_sv); end
    cyc();
    n_checks++; if (m_rd !== 32'd0) begin n_fail++; $display("FAIL clrsnap_rd: got %0d expected 0", m_rd); end
    // One further event must count from 0, proving the clear-cycle event was dropped
    event_i = 4'b0010;
    cyc();
    event_i = 4'b0000; snap = 1'b1;
    cyc();
    snap = 1'b0;
    cyc();
    n_checks++; if (m_rd !== 32'd1) begin n_fail++; $display("FAIL clrsnap_after: got %0d expected 1", m_rd); end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      event_i = 4'b0100;
      cyc();
    end
    n_checks++; if (w_ovf !== 4'b0000) begin n_fail++; $display("FAIL wrap_ovf_at15: got %b expected 0000", w_ovf); end
    n_checks++; if (s_ovf !== 4'b0000) begin n_fail++; $display("FAIL sat_ovf_at15: got %b expected 0000", s_ovf); end
    cyc();
    n_checks++; if (w_ovf !== 4'b0100) begin n_fail++; $display("FAIL wrap_ovf_at16: got %b expected 0100", w_ovf); end
    n_checks++; if (s_ovf !== 4'b0100) begin n_fail++; $display("FAIL sat_ovf_at16: got %b expected 0100", s_ovf); end
    cyc();
    event_i = 4'b0000; snap = 1'b1; sel = 2'd2;
    cyc();
    snap = 1'b0;
    cyc();
    n_checks++; if (w_rd !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 1", w_rd); end
    n_checks++; if (s_rd !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d expected 15", s_rd); end
    n_checks++; if (w_ovf !== 4'b0100) begin n_fail++; $display("FAIL wrap_ovf_sticky: got %b expected 0100", w_ovf); end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    n_checks++; if (w_ovf !== 4'b0000) begin n_fail++; $display("FAIL wrap_ovf_clr: got %b expected 0000", w_ovf); end
    n_checks++; if (s_ovf !== 4'b0000) begin n_fail++; $display("FAIL sat_ovf_clr: got %b expected 0000", s_ovf); end
    snap = 1'b1;
    cyc();
    snap = 1'b0;
    cyc();
    n_checks++; if (w_rd !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt_clr: got %0d expected 0", w_rd); end
    n_checks++; if (s_rd !== 4'd0) begin n_fail++; $display("FAIL sat_cnt_clr: got %0d expected 0", s_rd); end
  endtask

  task automatic test_halt();
    do_reset();
    sel = 2'd0;
    for (int c = 0; c < 30; c++) begin
      event_i = 4'b1111;
      halt = (c == 20 || c == 24);
      cyc();
      if (c == 19) begin
        n_checks++; if (m_halted !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b expected 0", m_halted); end
      end
      if (c == 20) begin
        n_checks++; if (m_halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b expected 1", m_halted); end
        n_checks++; if (m_sv !== 1'b1) begin n_fail++; $display("FAIL halt_autosnap_valid: got %b expected 1", m_sv); end
      end
    end
    halt = 1'b0;
    n_checks++; if (m_rd !== 32'd21) begin n_fail++; $display("FAIL halt_autosnap_ch0: got %0d expected 21", m_rd); end
    n_checks++; if (w_rd !== 4'd5) begin n_fail++; $display("FAIL halt_wrap_ch0: got %0d expected 5", w_rd); end
    n_checks++; if (s_rd !== 4'd15) begin n_fail++; $display("FAIL halt_sat_ch0: got %0d expected 15", s_rd); end
    n_checks++; if (w_ovf !== 4'b1111) begin n_fail++; $display("FAIL halt_wrap_ovf: got %b expected 1111", w_ovf); end
    // Manual snapshot while halted: counters must still read frozen values
    snap = 1'b1; sel = 2'd3;
    cyc();
    snap = 1'b0;
    cyc();
    n_checks++; if (m_rd !== 32'd21) begin n_fail++; $display("FAIL halt_frozen_ch3: got %0d expected 21", m_rd); end
    n_checks++; if (m_halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b expected 1", m_halted); end
  endtask

  task automatic test_reset_midop();
    sel = 2'd0;
    rst = 1'b0; event_i = 4'b1111;
    cyc();
    n_checks++; if (m_rd !== 32'd0) begin n_fail++; $display("FAIL midrst_rd: got %0d expected 0", m_rd); end
    n_checks++; if (m_halted !== 1'b0) begin n_fail++; $display("FAIL midrst_halted: got %b expected 0", m_halted); end
    n_checks++; if (m_sv !== 1'b0) begin n_fail++; $display("FAIL midrst_snap_valid: got %b expected 0", m_sv); end
    n_checks++; if (w_ovf !== 4'b0000) begin n_fail++; $display("FAIL midrst_ovf: got %b expected 0000", w_ovf); end
    rst = 1'b1; event_i = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cyc();
      n_checks++; if (m_rd !== 32'd0) begin n_fail++; $display("FAIL midrst_shadow%0d: got %0d expected 0", s, m_rd); end
    end
    snap = 1'b1;
    cyc();
    snap = 1'b0;
    cyc();
    n_checks++; if (m_rd !== 32'd0) begin n_fail++; $display("FAIL midrst_counter: got %0d expected 0", m_rd); end
  endtask

  task automatic test_sel_range();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      event_i = 4'b0111;
      cyc();
    end
    event_i = 4'b0000; snap = 1'b1; sel = 2'd2;
    cyc();
    snap = 1'b0;
    cyc();
    n_checks++; if (n_rd !== 8'd3) begin n_fail++; $display("FAIL sel_n3_ch2: got %0d expected 3", n_rd); end
    sel = 2'd3;
    cyc();
    n_checks++; if (n_rd !== 8'd0) begin n_fail++; $display("FAIL sel_n3_oob: got %0d expected 0", n_rd); end
    sel = 2'd1;
    cyc();
    n_checks++; if (n_rd !== 8'd3) begin n_fail++; $display("FAIL sel_n3_ch1: got %0d expected 3", n_rd); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_count();
    test_clear_snap();
    test_wrap_sat();
    test_halt();
    test_reset_midop();
    test_sel_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
